// File: rtl/core_msg_rx_pkg.sv
// Shared constants for the scheduler->core message bus: header field masks,
// fence codes, word positions within the task header frame, and receiver states.
package core_msg_rx_pkg;

  localparam logic [15:0] SCHED_IFNUM_MASK = 16'h003F;
  localparam logic [15:0] SCHED_FENCE_MASK = 16'h00C0;

  localparam logic [1:0] FENCE_NONE = 2'd0;
  localparam logic [1:0] FENCE_ACQ  = 2'd1;
  localparam logic [1:0] FENCE_REL  = 2'd2;

  localparam int W_HDR    = 0;
  localparam int W_MASK   = 1;
  localparam int W_R0MASK = 2;
  localparam int W_R0DATA = 3;

  localparam int MSG_FRAME_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_INSTR,
    ST_LAUNCH,
    ST_EXEC
  } rx_state_e;

  function automatic logic [5:0] hdr_if_num(input logic [15:0] w);
    return 6'(w & SCHED_IFNUM_MASK);
  endfunction

  function automatic logic [1:0] hdr_fence(input logic [15:0] w);
    return 2'((w & SCHED_FENCE_MASK) >> 6);
  endfunction

endpackage

// File: rtl/core_msg_rx.sv
// Per-core receiver for the scheduler message bus: follows task framing on every
// task, loads R0/IMEM only when this core is selected, then launches and waits.
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int BUS_W       = 16,
  parameter int FRAME_WORDS = MSG_FRAME_WORDS,
  parameter int R0_WORDS    = 8,
  parameter int IMEM_AW     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               msg_valid,
  input  logic               msg_first,
  input  logic [BUS_W-1:0]   msg_data,
  input  logic               core_done,
  output logic               core_ready,
  output logic               r0_wr_en,
  output logic [2:0]         r0_wr_idx,
  output logic [BUS_W-1:0]   r0_wr_data,
  output logic               imem_wr_en,
  output logic [IMEM_AW-1:0] imem_wr_addr,
  output logic [BUS_W-1:0]   imem_wr_data,
  output logic               task_start,
  output logic [1:0]         task_fence,
  output logic [IMEM_AW-1:0] task_len,
  output logic               err
);

  localparam int WCW = $clog2(FRAME_WORDS);
  localparam logic [WCW-1:0] LAST_W     = WCW'(FRAME_WORDS - 1);
  localparam logic [WCW-1:0] WC_MASK    = WCW'(W_MASK);
  localparam logic [WCW-1:0] WC_R0MASK  = WCW'(W_R0MASK);
  localparam logic [WCW-1:0] WC_R0      = WCW'(W_R0DATA);
  localparam logic [WCW-1:0] WC_R0_LAST = WCW'(W_R0DATA + R0_WORDS - 1);

  rx_state_e          state, state_nxt;
  logic [WCW-1:0]     word_cnt;
  logic [5:0]         frame_cnt;
  logic [5:0]         if_num;
  logic [1:0]         fence;
  logic               sel, r0_sel;
  logic               exec_busy, exec_busy_nxt;
  logic [IMEM_AW-1:0] imem_ptr;
  logic [WCW-1:0]     r0_off;

  logic new_task, abort, task_end, err_nxt;

  assign r0_off = word_cnt - WC_R0;

  always_comb begin
    state_nxt = state;
    new_task  = 1'b0;
    abort     = 1'b0;
    task_end  = 1'b0;
    err_nxt   = 1'b0;
    // Execution ends on core_done; a selected launch starts it. Tracking a task
    // while busy does not affect this.
    exec_busy_nxt = (exec_busy & ~core_done) | ((state == ST_LAUNCH) & sel);
    unique case (state)
      ST_HDR, ST_INSTR: begin
        if (msg_valid) begin
          if (msg_first) begin
            err_nxt   = 1'b1;
            abort     = 1'b1;
            new_task  = 1'b1;
            state_nxt = ST_HDR;
          end else if (state == ST_HDR) begin
            // Selected while still executing: track the task but refuse it.
            if (word_cnt == WC_MASK && exec_busy && msg_data[CORE_ID]) err_nxt = 1'b1;
            if (word_cnt == LAST_W) begin
              if (if_num == '0) begin
                task_end  = 1'b1;
                state_nxt = ST_LAUNCH;
              end else begin
                state_nxt = ST_INSTR;
              end
            end
          end else if (word_cnt == LAST_W && frame_cnt == 6'd1) begin
            task_end  = 1'b1;
            state_nxt = ST_LAUNCH;
          end
        end
      end
      default: begin
        if (msg_valid && msg_first) begin
          new_task  = 1'b1;
          state_nxt = ST_HDR;
        end else begin
          err_nxt   = msg_valid;
          state_nxt = exec_busy_nxt ? ST_EXEC : ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      word_cnt     <= '0;
      frame_cnt    <= '0;
      if_num       <= '0;
      fence        <= '0;
      sel          <= 1'b0;
      r0_sel       <= 1'b0;
      exec_busy    <= 1'b0;
      imem_ptr     <= '0;
      core_ready   <= 1'b1;
      r0_wr_en     <= 1'b0;
      r0_wr_idx    <= '0;
      r0_wr_data   <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      task_start   <= 1'b0;
      task_fence   <= '0;
      task_len     <= '0;
      err          <= 1'b0;
    end else begin
      state      <= state_nxt;
      exec_busy  <= exec_busy_nxt;
      err        <= err_nxt;
      r0_wr_en   <= 1'b0;
      imem_wr_en <= 1'b0;
      task_start <= 1'b0;

      if (exec_busy && core_done) core_ready <= 1'b1;

      if (new_task) begin
        word_cnt <= WCW'(W_HDR + 1);
        if_num   <= hdr_if_num(msg_data[15:0]);
        fence    <= hdr_fence(msg_data[15:0]);
        sel      <= 1'b0;
        r0_sel   <= 1'b0;
        imem_ptr <= '0;
        // An aborted selected task never launches, so the core is free again.
        if (abort && sel) core_ready <= 1'b1;
      end else if (msg_valid && state == ST_HDR) begin
        word_cnt  <= word_cnt + 1'b1;
        frame_cnt <= if_num;
        if (word_cnt == WC_MASK) begin
          sel <= msg_data[CORE_ID] & ~exec_busy;
          if (msg_data[CORE_ID] && !exec_busy) core_ready <= 1'b0;
        end
        if (word_cnt == WC_R0MASK) r0_sel <= msg_data[CORE_ID];
        if (sel && r0_sel && word_cnt >= WC_R0 && word_cnt <= WC_R0_LAST) begin
          r0_wr_en   <= 1'b1;
          r0_wr_idx  <= r0_off[2:0];
          r0_wr_data <= msg_data;
        end
      end else if (msg_valid && state == ST_INSTR) begin
        word_cnt <= word_cnt + 1'b1;
        if (word_cnt == LAST_W) frame_cnt <= frame_cnt - 6'd1;
        if (sel) begin
          imem_wr_en   <= 1'b1;
          imem_wr_addr <= imem_ptr;
          imem_wr_data <= msg_data;
          imem_ptr     <= imem_ptr + 1'b1;
        end
      end

      if (task_end) begin
        task_start <= sel;
        if (sel) begin
          task_fence <= fence;
          task_len   <= IMEM_AW'(if_num) << WCW;
        end
      end
    end
  end

endmodule
